// File: rtl/led_pattern_engine.sv
// LED pattern generator: rotate-left/right, ping-pong and bar-fill with prescaled advance.
// Optional PWM brightness control is enabled by defining LED_PATTERN_PWM_EN.
module led_pattern_engine #(
  parameter int unsigned LED_W = 8,
  parameter int unsigned CNT_W = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  input  logic             pause,
  input  logic             step,
`ifdef LED_PATTERN_PWM_EN
  input  logic [3:0]       bright,
`endif
  output logic [LED_W-1:0] led,
  output logic             tick,
  output logic             wrap
);

  typedef enum logic [1:0] {ModeRotL = 2'b00, ModeRotR = 2'b01, ModePing = 2'b10,
                            ModeBar = 2'b11} mode_e;
  typedef enum logic {DirUp = 1'b0, DirDown = 1'b1} dir_e;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [LED_W-1:0] PatLsb  = LED_W'(1);
  localparam logic [LED_W-1:0] PatMsb  = PatLsb << (LED_W - 1);
  localparam logic [LED_W-1:0] PatOnes = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d, tc;
  logic [LED_W-1:0] pat_q, pat_d;
  mode_e            mode_q, mode_d, mode_in;
  dir_e             dir_q, dir_d;
  logic             tick_q, wrap_q, wrap_d;
  logic             at_tc, adv, pat_onehot;

  function automatic logic [LED_W-1:0] init_pat(input mode_e m);
    return (m == ModeRotR) ? PatMsb : PatLsb;
  endfunction

  // Terminal count shrinks by 4x per speed step; >= lets a lowered TC take effect at once.
  assign tc      = CntMax >> {speed, 1'b0};
  assign at_tc   = (cnt_q >= tc);
  assign adv     = pause ? step : at_tc;
  assign cnt_d   = pause ? cnt_q : (at_tc ? '0 : cnt_q + CNT_W'(1));
  assign mode_in = mode_e'(mode);

  assign pat_onehot = (pat_q != '0) && ((pat_q & (pat_q - PatLsb)) == '0);

  always_comb begin
    pat_d  = pat_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    if (mode_in != mode_q) begin
      mode_d = mode_in;
      pat_d  = init_pat(mode_in);
      dir_d  = DirUp;
    end else if (mode_q != ModeBar && !pat_onehot) begin
      // Recover from a corrupted one-hot state.
      pat_d = init_pat(mode_q);
      dir_d = DirUp;
    end else begin
      unique case (mode_q)
        ModeRotL: begin
          pat_d  = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
          wrap_d = pat_q[LED_W-1];
        end
        ModeRotR: begin
          pat_d  = {pat_q[0], pat_q[LED_W-1:1]};
          wrap_d = pat_q[0];
        end
        ModePing: begin
          if (dir_q == DirUp) begin
            if (pat_q[LED_W-1]) begin
              pat_d = pat_q >> 1;
              dir_d = DirDown;
            end else begin
              pat_d = pat_q << 1;
              if (pat_q[LED_W-2]) dir_d = DirDown;
            end
          end else begin
            if (pat_q[0]) begin
              pat_d = pat_q << 1;
              dir_d = DirUp;
            end else begin
              pat_d = pat_q >> 1;
              if (pat_q[1]) begin
                dir_d  = DirUp;
                wrap_d = 1'b1;
              end
            end
          end
        end
        ModeBar: begin
          if (pat_q == PatOnes) begin
            pat_d  = '0;
            wrap_d = 1'b1;
          end else begin
            pat_d = (pat_q << 1) | PatLsb;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      pat_q  <= PatLsb;
      mode_q <= ModeRotL;
      dir_q  <= DirUp;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= adv;
      wrap_q <= adv & wrap_d;
      if (adv) begin
        pat_q  <= pat_d;
        mode_q <= mode_d;
        dir_q  <= dir_d;
      end
    end
  end

`ifdef LED_PATTERN_PWM_EN
  logic [3:0]       pwm_cnt_q;
  logic [LED_W-1:0] led_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pwm_cnt_q <= 4'd0;
      led_q     <= PatLsb;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
      led_q     <= (adv ? pat_d : pat_q) & {LED_W{pwm_cnt_q < bright}};
    end
  end

  assign led = led_q;
`else
  assign led = pat_q;
`endif

  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine (LED_W=8, CNT_W=4) using an expected-advance queue.
module tb_led_pattern_engine;

  localparam int LED_W = 8;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       mode  = 2'b00;
  logic [1:0]       speed = 2'b00;
  logic             pause = 1'b0;
  logic             step  = 1'b0;
`ifdef LED_PATTERN_PWM_EN
  logic [3:0]       bright = 4'd15;
`endif
  logic [LED_W-1:0] led;
  logic             tick;
  logic             wrap;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [LED_W-1:0] led;
    logic             wrap;
    int               gap;
  } exp_t;

  exp_t sb[$];

  led_pattern_engine #(.LED_W(LED_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .mode  (mode),
    .speed (speed),
    .pause (pause),
    .step  (step),
`ifdef LED_PATTERN_PWM_EN
    .bright(bright),
`endif
    .led   (led),
    .tick  (tick),
    .wrap  (wrap)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push(input logic [LED_W-1:0] l, input logic w, input int gap);
    exp_t e;
    e.led  = l;
    e.wrap = w;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  // Pops one expected advance and waits (bounded) for the DUT tick that should produce it.
  task automatic expect_tick(input string name);
    exp_t e;
    int   cyc;
    bit   stray;
    bit   led_ok;
    cyc   = 0;
    stray = 1'b0;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    do begin
      @(negedge clock);
      cyc++;
      if (!tick && wrap) stray = 1'b1;
    end while (!tick && cyc < e.gap + 4);
    n_tests++;
    if (tick !== 1'b1 || cyc != e.gap) begin
      n_fail++;
      $display("FAIL %s gap: got %0d cycles (tick=%b), expected %0d", name, cyc, tick, e.gap);
    end
`ifdef LED_PATTERN_PWM_EN
    led_ok = (led === e.led) || (led === '0);
`else
    led_ok = (led === e.led);
`endif
    n_tests++;
    if (!led_ok) begin
      n_fail++;
      $display("FAIL %s led: got %h, expected %h", name, led, e.led);
    end
    n_tests++;
    if (wrap !== e.wrap) begin
      n_fail++;
      $display("FAIL %s wrap: got %b, expected %b (led %h)", name, wrap, e.wrap, e.led);
    end
    n_tests++;
    if (stray) begin
      n_fail++;
      $display("FAIL %s stray wrap: got wrap=1 without tick, expected 0", name);
    end
  endtask

  task automatic drain(input string name);
    while (sb.size() != 0) expect_tick(name);
  endtask

  task automatic idle_no_tick(input string name, input int n, input logic [LED_W-1:0] exp_led);
    int bad_tick;
    int bad_led;
    bad_tick = 0;
    bad_led  = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (tick !== 1'b0) bad_tick++;
`ifndef LED_PATTERN_PWM_EN
      if (led !== exp_led) bad_led++;
`endif
    end
    n_tests++;
    if (bad_tick != 0 || bad_led != 0) begin
      n_fail++;
      $display("FAIL %s idle: got %0d ticks, %0d led changes, expected 0 (led %h)",
               name, bad_tick, bad_led, exp_led);
    end
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if (led !== 8'h01 || tick !== 1'b0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got led=%h tick=%b wrap=%b, expected 01/0/0", led, tick, wrap);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_rotate_left();
    logic [LED_W-1:0] one;
    one = 1;
    for (int i = 1; i <= 8; i++) push(one << (i % 8), (i == 8), 16);
    drain("rotl");
  endtask

  task automatic test_speed();
    speed = 2'd1;
    push(8'h02, 1'b0, 4);
    push(8'h04, 1'b0, 4);
    push(8'h08, 1'b0, 4);
    drain("speed1");
    speed = 2'd0;
    idle_no_tick("speed0_count", 9, 8'h08);
    speed = 2'd2;
    push(8'h10, 1'b0, 1);
    push(8'h20, 1'b0, 1);
    drain("speed2");
  endtask

  task automatic test_pingpong();
    logic [LED_W-1:0] one;
    one   = 1;
    mode  = 2'b10;
    speed = 2'd3;
    push(8'h01, 1'b0, 1);
    for (int i = 1; i <= 7; i++) push(one << i, 1'b0, 1);
    for (int i = 6; i >= 0; i--) push(one << i, (i == 0), 1);
    push(8'h02, 1'b0, 1);
    push(8'h04, 1'b0, 1);
    push(8'h08, 1'b0, 1);
    drain("pingpong");
    mode = 2'b01;
    push(8'h80, 1'b0, 1);
    push(8'h40, 1'b0, 1);
    drain("mode_switch");
  endtask

  task automatic test_barfill();
    mode = 2'b11;
    for (int i = 0; i < 8; i++) push(LED_W'((1 << (i + 1)) - 1), 1'b0, 1);
    push(8'h00, 1'b1, 1);
    push(8'h01, 1'b0, 1);
    drain("barfill");
  endtask

  task automatic test_pause_step();
    speed = 2'd1;
    @(negedge clock);
    @(negedge clock);
    pause = 1'b1;
    idle_no_tick("pause_hold", 50, 8'h01);
    for (int k = 0; k < 3; k++) begin
      push(LED_W'((1 << (k + 2)) - 1), 1'b0, 1);
      step = 1'b1;
      expect_tick("step");
      step = 1'b0;
      idle_no_tick("step_gap", 2, LED_W'((1 << (k + 2)) - 1));
    end
    // Counter was frozen at 2, so two more clocks reach TC=3.
    pause = 1'b0;
    push(8'h1F, 1'b0, 2);
    expect_tick("resume");
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
    n_tests++;
    if (tick !== 1'b0) begin
      n_fail++;
      $display("FAIL step_unpaused: got tick=%b, expected 0", tick);
    end
    push(8'h3F, 1'b0, 3);
    expect_tick("step_unpaused_next");
    repeat (3) @(negedge clock);
    pause = 1'b1;
    idle_no_tick("pause_at_tc", 5, 8'h3F);
    pause = 1'b0;
    push(8'h7F, 1'b0, 1);
    expect_tick("pause_release");
    repeat (3) @(negedge clock);
    step = 1'b1;
    push(8'hFF, 1'b0, 1);
    expect_tick("step_with_tc");
    step = 1'b0;
    push(8'h00, 1'b1, 4);
    expect_tick("step_with_tc_next");
  endtask

  task automatic test_async_reset();
    mode  = 2'b00;
    speed = 2'd2;
    push(8'h01, 1'b0, 1);
    push(8'h02, 1'b0, 1);
    push(8'h04, 1'b0, 1);
    drain("pre_reset");
    #1;
    reset = 1'b0;
    #1;
    n_tests++;
    if (led !== 8'h01 || tick !== 1'b0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got led=%h tick=%b wrap=%b, expected 01/0/0", led, tick, wrap);
    end
    speed = 2'd0;
    @(negedge clock);
    reset = 1'b1;
    push(8'h02, 1'b0, 16);
    drain("post_reset");
  endtask

`ifdef LED_PATTERN_PWM_EN
  task automatic test_pwm();
    int on_cnt;
    pause  = 1'b1;
    bright = 4'd4;
    on_cnt = 0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      if (led != '0) on_cnt++;
    end
    n_tests++;
    if (on_cnt != 8) begin
      n_fail++;
      $display("FAIL pwm_bright4: got %0d on-cycles of 32, expected 8", on_cnt);
    end
    bright = 4'd0;
    on_cnt = 0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (led != '0) on_cnt++;
    end
    n_tests++;
    if (on_cnt != 0) begin
      n_fail++;
      $display("FAIL pwm_bright0: got %0d on-cycles of 16, expected 0", on_cnt);
    end
    pause = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_rotate_left();
    test_speed();
    test_pingpong();
    test_barfill();
    test_pause_step();
    test_async_reset();
`ifdef LED_PATTERN_PWM_EN
    test_pwm();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
